lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Serial PRBS checker, the receive end of the `lfsr` generator. It takes the generator's serial output stream one bit per valid cycle and self-synchronises a local copy of the same recurrence. It then flags every bit that disagrees with the prediction. It sits downstream of `lfsr` in loopback and link bring-up paths and reports lock status plus a saturating error count.

## Interface
- `N`, 3: LFSR length. Must match the generator. Legal range is 2..8.
- `LOCK_CNT`, 8: consecutive correct predictions needed to declare lock.
- `WINDOW`, 16: length, in valid bits, of the error-rate window while locked.
- `ERR_THRESH`, 4: errors within one window that force loss of lock.
- `CNT_W`, 16: width of `err_count`.

- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din_valid`  in  1  `din` carries a stream bit this cycle.
- `din`  in  1  received serial bit, which is the generator's `Q[N]`.
- `err_clr`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  checker is in the LOCKED state.
- `err_pulse`  out  1  one-cycle pulse for each mispredicted bit while LOCKED.
- `err_count`  out  CNT_W  total LOCKED-state errors, saturating at all-ones.

## Operation
- The stream obeys b[t] = XOR of b[t-k] over the tap set T(N). T(N) is the generator's feedback taps. For N=3, T = {2,3}, so b[t] = b[t-2] ^ b[t-3].
- `hist[N-1:0]` holds the last N bits. The prediction `pred` = XOR of the tapped `hist` bits.
- Nothing advances on cycles where `din_valid`=0.
- FSM states are FILL, SEARCH and LOCKED. Reset enters FILL.
- FILL: shift `din` into `hist` and count N valid bits, then go to SEARCH.
- SEARCH:
  - Each valid bit compares `din` with `pred`, then shifts `din` into `hist`.
  - A match increments `match_cnt`. A mismatch clears it.
  - A match while `hist` is all-zero does not count and clears `match_cnt`. This is the lock-up guard.
  - When `match_cnt` reaches `LOCK_CNT`, go to LOCKED and clear the window counters.
- LOCKED:
  - `hist` free-runs by shifting in `pred`, not `din`, so a single channel error cannot corrupt later predictions.
  - When `din` != `pred`, pulse `err_pulse`, increment `err_count` (saturating), and increment `win_err`.
  - `win_bits` counts valid bits 0..WINDOW-1, then wraps. On the wrap, `win_err` clears.
  - When `win_err` reaches `ERR_THRESH`, go to SEARCH and clear `match_cnt`. `hist` is reloaded by shifting `din` in from then on.
- Errors in FILL or SEARCH are not counted and do not pulse.
- `err_clr` together with a counted error in the same cycle gives `err_count` = 1. `err_clr` alone gives 0.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, state FILL, `hist`=0, and all internal counters 0.
- All outputs are registered, with one-cycle latency from the deciding `din_valid` cycle.
- `locked` rises on the cycle after the `LOCK_CNT`-th qualifying match. From reset, a clean stream gives N+LOCK_CNT valid bits to lock.
- `err_pulse` is high for exactly one cycle after each erroneous valid bit. Back-to-back errors give back-to-back pulses.
- Threshold error: `err_pulse`=1 and `locked`=0 appear in the same cycle. That error is still counted.
- An error on the last bit of a window (`win_bits`=WINDOW-1) counts toward the ending window, and then both window counters clear.
- `reset` mid-stream overrides everything, including a same-cycle error, and returns to FILL.
- `din_valid` may toggle arbitrarily. Gaps do not affect the result.

## Structure
- Package `lfsr_pkg`:
  - function `lfsr_taps(N)` returns an 8-bit tap mask, shared with `lfsr` so both ends agree.
  - FSM state typedef `chk_state_t` {FILL, SEARCH, LOCKED}.
- Sub-module `lfsr_predict`: combinational `pred` from `hist` and the tap mask. The FSM, counters and saturation logic stay in `lfsr_checker`.

## Test plan
- Clean lock:
  - Stimulus: N=3, continuous stream 0,0,1,0,1,1,1 repeating.
  - Required response: `locked` rises on the cycle after the 11th valid bit, and `err_count` stays 0 for 100 bits.
- Single error:
  - Stimulus: after lock, flip one bit.
  - Required response: exactly one `err_pulse`, `err_count`=1, `locked` stays 1, and no follow-on errors.
- Loss of lock:
  - Stimulus: after lock, flip 4 bits within one 16-bit window.
  - Required response: `locked` falls in the same cycle as the 4th pulse, `err_count`=4, and the checker relocks after 8 more clean bits.
- Window wrap:
  - Stimulus: 3 errors in window k, then 3 errors in window k+1.
  - Required response: `locked` stays 1 and `err_count`=6.
- All-zero input:
  - Stimulus: 50 valid bits of `din`=0.
  - Required response: `locked` never asserts.
- Gaps, clear and reset:
  - Stimulus: `din_valid` at 50% random with a clean stream, then `err_clr` asserted in the same cycle as an error, then `reset` mid-lock.
  - Required response: lock is reached after 11 valid bits, `err_count`=1 after the clear, and all outputs are 0 on the cycle after `reset`.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Types and the tap table shared by the PRBS generator and checker.
// Both ends read lfsr_taps() so their recurrences cannot drift apart.
package lfsr_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Bit k-1 of the mask selects tap k, i.e. b[t-k] in b[t] = XOR of the tapped history.
  function automatic logic [7:0] lfsr_taps(input int n);
    logic [7:0] mask;
    case (n)
      2:       mask = 8'b0000_0011;
      3:       mask = 8'b0000_0110;
      4:       mask = 8'b0000_1100;
      5:       mask = 8'b0001_0100;
      6:       mask = 8'b0011_0000;
      7:       mask = 8'b0110_0000;
      8:       mask = 8'b1011_1000;
      default: mask = 8'b0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream input and status output bundle of the PRBS checker.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             din_valid;
  logic             din;
  logic             err_clr;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output din_valid, din, err_clr,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  din_valid, din, err_clr,
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/lfsr_predict.sv
// Combinational next-bit prediction: XOR of the tapped history bits.
module lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] hist,
  output logic         pred
);
  localparam logic [7:0]   TAPS_FULL = lfsr_taps(N);
  localparam logic [N-1:0] TAPS      = TAPS_FULL[N-1:0];

  logic [N-1:0] tapped;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_tap
      assign tapped[gi] = hist[gi] & TAPS[gi];
    end
  endgenerate

  assign pred = ^tapped;
endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising serial PRBS checker with lock detection and a
// saturating count of errors seen while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int N          = 3,
  parameter int LOCK_CNT   = 8,
  parameter int WINDOW     = 16,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input logic            clk,
  input logic            reset,
  lfsr_checker_if.slave  bus
);
  localparam int FW  = $clog2(N + 1);
  localparam int MW  = $clog2(LOCK_CNT + 1);
  localparam int WBW = $clog2(WINDOW + 1);
  localparam int EW  = $clog2(ERR_THRESH + 1);

  localparam logic [FW-1:0]    FILL_LAST   = FW'(N - 1);
  localparam logic [MW-1:0]    LOCK_LAST   = MW'(LOCK_CNT - 1);
  localparam logic [WBW-1:0]   WIN_LAST    = WBW'(WINDOW - 1);
  localparam logic [EW-1:0]    THRESH_LAST = EW'(ERR_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  chk_state_t       state_reg;
  logic [N-1:0]     hist_reg;
  logic [FW-1:0]    fill_cnt_reg;
  logic [MW-1:0]    match_cnt_reg;
  logic [WBW-1:0]   win_bits_reg;
  logic [EW-1:0]    win_err_reg;
  logic             locked_reg;
  logic             err_pulse_reg;
  logic [CNT_W-1:0] err_count_reg;

  logic pred;
  logic miss;
  logic hist_zero;
  logic counted_err;
  logic shift_bit;

  lfsr_predict #(.N(N)) u_predict (
    .hist (hist_reg),
    .pred (pred)
  );

  assign miss        = bus.din ^ pred;
  assign hist_zero   = (hist_reg == '0);
  assign counted_err = bus.din_valid && (state_reg == LOCKED) && miss;
  // While locked the history regenerates itself so channel errors never enter it.
  assign shift_bit   = (state_reg == LOCKED) ? pred : bus.din;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FILL;
      hist_reg      <= '0;
      fill_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      win_bits_reg  <= '0;
      win_err_reg   <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      err_pulse_reg <= counted_err;

      if (bus.err_clr)
        err_count_reg <= counted_err ? CNT_ONE : '0;
      else if (counted_err && !(&err_count_reg))
        err_count_reg <= err_count_reg + 1'b1;

      if (bus.din_valid) begin
        hist_reg <= {hist_reg[N-2:0], shift_bit};
        case (state_reg)
          FILL: begin
            if (fill_cnt_reg == FILL_LAST) begin
              fill_cnt_reg <= '0;
              state_reg    <= SEARCH;
            end else begin
              fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
          end
          SEARCH: begin
            // A match against an all-zero history proves nothing: it is the lock-up state.
            if (!miss && !hist_zero) begin
              if (match_cnt_reg == LOCK_LAST) begin
                state_reg     <= LOCKED;
                locked_reg    <= 1'b1;
                match_cnt_reg <= '0;
                win_bits_reg  <= '0;
                win_err_reg   <= '0;
              end else begin
                match_cnt_reg <= match_cnt_reg + 1'b1;
              end
            end else begin
              match_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            if (miss && (win_err_reg == THRESH_LAST)) begin
              state_reg     <= SEARCH;
              locked_reg    <= 1'b0;
              match_cnt_reg <= '0;
              win_bits_reg  <= '0;
              win_err_reg   <= '0;
            end else if (win_bits_reg == WIN_LAST) begin
              win_bits_reg <= '0;
              win_err_reg  <= '0;
            end else begin
              win_bits_reg <= win_bits_reg + 1'b1;
              if (miss)
                win_err_reg <= win_err_reg + 1'b1;
            end
          end
          default: state_reg <= FILL;
        endcase
      end
    end
  end

  assign bus.locked    = locked_reg;
  assign bus.err_pulse = err_pulse_reg;
  assign bus.err_count = err_count_reg;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (N=3): stimulus queues hand-derived expected
// outputs, an independent monitor pops one entry per clock and compares.
module tb_lfsr_checker;
  logic clk;
  logic reset;

  lfsr_checker_if #(.CNT_W(16)) bus ();

  lfsr_checker #(
    .N(3), .LOCK_CNT(8), .WINDOW(16), .ERR_THRESH(4), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        lock;
    logic        pulse;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    txn      = 0;
  int    p        = 0;

  // One period of the N=3 sequence b[t] = b[t-2] ^ b[t-3].
  logic seq_bits [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic step(input logic v, input logic d, input logic clr, input logic rst,
                      input logic el, input logic ep, input logic [15:0] ec, input string nm);
    exp_t e;
    @(negedge clk);
    bus.din_valid = v;
    bus.din       = d;
    bus.err_clr   = clr;
    reset         = rst;
    e.lock  = el;
    e.pulse = ep;
    e.cnt   = ec;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic clean(input int n, input logic el, input logic [15:0] ec, input string nm);
    for (int i = 0; i < n; i++) begin
      step(1'b1, seq_bits[p % 7], 1'b0, 1'b0, el, 1'b0, ec, nm);
      p++;
    end
  endtask

  task automatic bad(input logic el, input logic [15:0] ec, input string nm);
    step(1'b1, ~seq_bits[p % 7], 1'b0, 1'b0, el, 1'b1, ec, nm);
    p++;
  endtask

  task automatic reset_lock(input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, {nm, "_reset"});
    p = 0;
    for (int k = 1; k <= 11; k++) begin
      step(1'b1, seq_bits[p % 7], 1'b0, 1'b0, (k == 11), 1'b0, 16'd0, {nm, "_acquire"});
      p++;
    end
  endtask

  // Monitor: outputs are registered, so each entry is checked just after the edge that consumed it.
  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        txn++;
        $display("txn %0d %s: locked=%0b pulse=%0b count=%0d (want %0b %0b %0d)",
                 txn, nm, bus.locked, bus.err_pulse, bus.err_count, e.lock, e.pulse, e.cnt);
        checks++;
        if (bus.locked !== e.lock) begin
          failures++;
          $display("FAIL %s locked: got %0b want %0b", nm, bus.locked, e.lock);
        end
        checks++;
        if (bus.err_pulse !== e.pulse) begin
          failures++;
          $display("FAIL %s err_pulse: got %0b want %0b", nm, bus.err_pulse, e.pulse);
        end
        checks++;
        if (bus.err_count !== e.cnt) begin
          failures++;
          $display("FAIL %s err_count: got %0d want %0d", nm, bus.err_count, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int vcnt;
    logic v;
    logic d;
    bus.din_valid = 1'b0;
    bus.din       = 1'b0;
    bus.err_clr   = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);

    // Clean lock on bit 11, then no errors up to 100 bits.
    reset_lock("clean");
    clean(89, 1'b1, 16'd0, "clean_run");

    // Single flipped bit after lock.
    reset_lock("single");
    clean(5, 1'b1, 16'd0, "single_pre");
    bad(1'b1, 16'd1, "single_err");
    clean(20, 1'b1, 16'd1, "single_post");

    // Four errors in window 0: lock drops with the 4th pulse, relock after 8 clean bits.
    reset_lock("loss");
    clean(2, 1'b1, 16'd0, "loss_pre");
    bad(1'b1, 16'd1, "loss_err1");
    clean(1, 1'b1, 16'd1, "loss_gap");
    bad(1'b1, 16'd2, "loss_err2");
    clean(1, 1'b1, 16'd2, "loss_gap");
    bad(1'b1, 16'd3, "loss_err3");
    clean(1, 1'b1, 16'd3, "loss_gap");
    bad(1'b0, 16'd4, "loss_thresh");
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, seq_bits[p % 7], 1'b0, 1'b0, (k == 8), 1'b0, 16'd4, "loss_relock");
      p++;
    end
    clean(5, 1'b1, 16'd4, "loss_post");

    // Three errors ending on the last bit of window 0, then three back-to-back in window 1.
    reset_lock("wrap");
    clean(5, 1'b1, 16'd0, "wrap_w0");
    bad(1'b1, 16'd1, "wrap_w0_err");
    clean(4, 1'b1, 16'd1, "wrap_w0");
    bad(1'b1, 16'd2, "wrap_w0_err");
    clean(4, 1'b1, 16'd2, "wrap_w0");
    bad(1'b1, 16'd3, "wrap_w0_last");
    bad(1'b1, 16'd4, "wrap_w1_err");
    bad(1'b1, 16'd5, "wrap_w1_err");
    bad(1'b1, 16'd6, "wrap_w1_err");
    clean(10, 1'b1, 16'd6, "wrap_post");

    // All-zero stream must never lock.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, "zeros_reset");
    for (int i = 0; i < 50; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "zeros");

    // Random valid gaps with garbage on idle cycles; lock after 11 valid bits.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, "gaps_reset");
    p    = 0;
    vcnt = 0;
    while (vcnt < 30) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        d = seq_bits[p % 7];
        p++;
        vcnt++;
      end else begin
        d = 1'($urandom_range(0, 1));
      end
      step(v, d, 1'b0, 1'b0, (vcnt >= 11), 1'b0, 16'd0, "gaps");
    end
    bad(1'b1, 16'd1, "gaps_err");
    clean(2, 1'b1, 16'd1, "gaps_post");
    step(1'b1, ~seq_bits[p % 7], 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, "clr_with_err");
    p++;
    step(1'b1, seq_bits[p % 7], 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, "clr_alone");
    p++;
    clean(2, 1'b1, 16'd0, "clr_post");
    step(1'b1, ~seq_bits[p % 7], 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, "reset_mid_err");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "after_reset");

    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.err_clr   = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
